// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: slave FSM state encoding and select-width helper.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } wb_slave_state_t;

  function automatic int wb_sel_width(input int data_width, input int granule);
    return data_width / granule;
  endfunction

endpackage

// File: rtl/wb_slave_mem_ram.sv
// Synchronous single-port RAM with per-lane write enables and registered read data.
module wb_slave_mem_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int GRANULE    = 8,
  parameter int DEPTH      = 16,
  parameter int SEL_WIDTH  = 4,
  parameter int IDX_WIDTH  = 4
) (
  input  logic                  clk_i,
  input  logic [IDX_WIDTH-1:0]  addr,
  input  logic [SEL_WIDTH-1:0]  we,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < SEL_WIDTH; k++) begin
      if (we[k]) begin
        mem[addr][k*GRANULE +: GRANULE] <= wdata[k*GRANULE +: GRANULE];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone classic slave memory with programmable wait states and byte-lane writes.
// Define WB_SLAVE_MEM_ERR_EN to terminate out-of-range or misaligned accesses with err_o.
module wb_slave_mem
  import wb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    GRANULE     = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 16'h2000,
  parameter int                    DEPTH       = 16,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                                           clk_i,
  input  logic                                           rst_i,
  input  logic                                           cyc_i,
  input  logic                                           stb_i,
  input  logic                                           we_i,
  input  logic [ADDR_WIDTH-1:0]                          adr_i,
  input  logic [DATA_WIDTH-1:0]                          dat_i,
  input  logic [wb_sel_width(DATA_WIDTH, GRANULE)-1:0]   sel_i,
  output logic [DATA_WIDTH-1:0]                          dat_o,
  output logic                                           ack_o,
  output logic                                           err_o
);

  localparam int SEL_WIDTH = wb_sel_width(DATA_WIDTH, GRANULE);
  localparam int IDX_WIDTH = $clog2(DEPTH);
  localparam int OFF_WIDTH = $clog2(DATA_WIDTH / 8);

  wb_slave_state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       latch, ram_wr, ack_n, err_n, resp_err;

  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_adr;
  logic [DATA_WIDTH-1:0] req_dat;
  logic [SEL_WIDTH-1:0]  req_sel;

  logic [IDX_WIDTH-1:0]  ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Out-of-range indices wrap modulo DEPTH through the truncating cast.
  function automatic logic [IDX_WIDTH-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return IDX_WIDTH'(off >> OFF_WIDTH);
  endfunction

`ifdef WB_SLAVE_MEM_ERR_EN
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF_WIDTH) - 1);
  logic [ADDR_WIDTH-1:0] req_off;
  assign req_off  = req_adr - BASE_ADDR;
  assign resp_err = (req_adr < BASE_ADDR)
                  || ((req_off >> OFF_WIDTH) >= ADDR_WIDTH'(DEPTH))
                  || ((req_off & OFF_MASK) != '0);
`else
  assign resp_err = 1'b0;
`endif

  // Read address follows the bus while idle so registered read data is ready by RESP.
  assign ram_addr = (state == IDLE) ? word_idx(adr_i) : word_idx(req_adr);

  wb_slave_mem_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .GRANULE    (GRANULE),
    .DEPTH      (DEPTH),
    .SEL_WIDTH  (SEL_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_ram (
    .clk_i (clk_i),
    .addr  (ram_addr),
    .we    ({SEL_WIDTH{ram_wr}} & req_sel),
    .wdata (req_dat),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    latch   = 1'b0;
    ram_wr  = 1'b0;
    ack_n   = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (cyc_i && stb_i) begin
          latch   = 1'b1;
          cnt_n   = 4'(WAIT_STATES);
          state_n = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (!(cyc_i && stb_i)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == 4'd1) begin
          state_n = RESP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      RESP: begin
        state_n = IDLE;
        err_n   = resp_err;
        ack_n   = !resp_err;
        ram_wr  = req_we && !resp_err;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      dat_o   <= '0;
      req_we  <= 1'b0;
      req_adr <= '0;
      req_dat <= '0;
      req_sel <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ack_o <= ack_n;
      err_o <= err_n;
      if (latch) begin
        req_we  <= we_i;
        req_adr <= adr_i;
        req_dat <= dat_i;
        req_sel <= sel_i;
      end
      if (state == RESP) begin
        if (resp_err) begin
          dat_o <= '0;
        end else if (!req_we) begin
          dat_o <= ram_rdata;
        end
      end
    end
  end

endmodule

// File: doc/wb_slave_mem.md
# wb_slave_mem

Wishbone classic-cycle slave exposing a byte-addressed, word-organised RAM with a programmable number of wait states and byte-lane writes. It is the responder counterpart to the team's sequential memory-access master: it sits on an `i2s_stb_o` line of `wb_intercon` and drives `ack`, `err` and `dat` back through `s2i_*`. It gives benches and small SoCs a realistic memory target with latency and error responses.

## Interface
Parameters:
- `ADDR_WIDTH`, 16, width of `adr_i`; byte address.
- `DATA_WIDTH`, 32, data bus width; a multiple of `GRANULE`.
- `GRANULE`, 8, bits per select lane; `SEL_WIDTH = DATA_WIDTH/GRANULE`.
- `BASE_ADDR`, 16'h2000, byte address of word 0.
- `DEPTH`, 16, number of words; a power of two, at least 2.
- `WAIT_STATES`, 0, extra cycles inserted before `ack_o`/`err_o`; range 0..15.

Ports:
- `clk_i` in 1: single clock; all logic is on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `cyc_i` in 1: bus cycle in progress.
- `stb_i` in 1: strobe for this slave.
- `we_i` in 1: 1 = write, 0 = read.
- `adr_i` in `ADDR_WIDTH`: byte address.
- `dat_i` in `DATA_WIDTH`: write data.
- `sel_i` in `SEL_WIDTH`: byte-lane enables.
- `dat_o` out `DATA_WIDTH`: read data.
- `ack_o` out 1: normal termination.
- `err_o` out 1: error termination.

## Operation
- Word index = (`adr_i` − `BASE_ADDR`) >> log2(`DATA_WIDTH`/8).
- FSM states are IDLE, WAIT and RESP.
  - IDLE: when `cyc_i & stb_i` is sampled, latch `we_i`, `adr_i`, `dat_i` and `sel_i`, then load the wait counter with `WAIT_STATES`. Go to WAIT if `WAIT_STATES` > 0, otherwise to RESP.
  - WAIT: decrement the counter each cycle. When it reaches 1, go to RESP. If `cyc_i` or `stb_i` drops, abort to IDLE with no memory side effect and no termination.
  - RESP: assert exactly one of `ack_o`/`err_o` for one cycle, then return to IDLE.
- Termination is evaluated using the latched request.
  - Write with ack: write the RAM in RESP, only on lanes where `sel_i[k]` = 1. `sel_i` = 0 still acks and changes nothing.
  - Read with ack: `dat_o` is loaded with the RAM word in the same edge that raises `ack_o`. `dat_o` holds that value until the next read ack.
  - Error: `dat_o` is 0 and there is no RAM write.
- A back-to-back strobe held high after ack starts a new transfer: IDLE samples it in the cycle after RESP.
- RAM contents are not cleared by reset.

## Timing
- Reset values: `ack_o` = 0, `err_o` = 0, `dat_o` = 0, FSM = IDLE, counter = 0.
- Latency: `ack_o`/`err_o` is high `WAIT_STATES` + 1 cycles after the edge that samples the strobe. Throughput is one transfer per `WAIT_STATES` + 2 cycles.
- `ack_o` and `err_o` are never high together and never high for more than one cycle per transfer.
- Reset asserted mid-transfer clears outputs immediately (asynchronous); a pending write is discarded.
- Changes to `adr_i`/`dat_i` after the sampling edge are ignored.

## Configuration
- `WB_SLAVE_MEM_ERR_EN` defined:
  - An address below `BASE_ADDR`, a word index ≥ `DEPTH`, or nonzero low byte-offset bits terminates with `err_o`.
- Undefined:
  - `err_o` is tied 0.
  - The word index wraps modulo `DEPTH` and offset bits are ignored.
  - Every transfer terminates with `ack_o`.

## Structure
- The shared package `wb_pkg` holds:
  - the state enum `wb_slave_state_t` (IDLE, WAIT, RESP);
  - the function `wb_sel_width(DATA_WIDTH, GRANULE)`.
- One sub-module, `wb_slave_mem_ram`: a synchronous single-port RAM with per-lane write enables.
- The FSM, request latch, range check and counter stay in the top.

## Test plan
- Reset with all inputs active: hold `rst_i` mid-WAIT → `ack_o`, `err_o` and `dat_o` are 0 asynchronously; after release, the next idle strobe produces a normal transfer.
- Write then read, `WAIT_STATES` = 0:
  - Write 32'hDEADBEEF to 16'h2004 with `sel_i` = 4'hF → `ack_o` exactly 1 cycle after the strobe is sampled.
  - Read 16'h2004 → `ack_o` after 1 cycle with `dat_o` = 32'hDEADBEEF.
- Byte lanes: write 32'h11223344 with `sel_i` = 4'b0101 over word 32'hDEADBEEF → read returns 32'hDE22BE44.
- `WAIT_STATES` = 3:
  - A read acks 4 cycles after sampling, and a back-to-back held strobe acks again 5 cycles later.
  - Dropping `cyc_i` in WAIT gives no ack and no write.
- With `WB_SLAVE_MEM_ERR_EN`:
  - 16'h1FFC, 16'h2040 (`DEPTH` 16) and 16'h2002 → each gives a single `err_o` pulse with `dat_o` = 0 and no RAM change.
- Without the macro: 16'h2040 acks and aliases word 0, so a read there returns the value written at 16'h2000.
